// File: rtl/rhd_emu_pkg.sv
// Shared constants, opcode classes and ROM lookup for the RHD2000 chip emulator.
// Imported by the emulator top and its helpers.
package rhd_emu_pkg;

  localparam logic [1:0] CMD_CONVERT = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b10;
  localparam logic [1:0] CMD_READ = 2'b11;
  localparam logic [15:0] CMD_CALIBRATE = 16'h5500;
  localparam logic [15:0] CMD_CLEAR = 16'h6A00;

  localparam int RHD_NUM_WR_REGS = 18;

  localparam logic [5:0] ROM_NAME_0 = 6'd40;
  localparam logic [5:0] ROM_NAME_1 = 6'd41;
  localparam logic [5:0] ROM_NAME_2 = 6'd42;
  localparam logic [5:0] ROM_NAME_3 = 6'd43;
  localparam logic [5:0] ROM_NAME_4 = 6'd44;
  localparam logic [5:0] ROM_MISO_AB = 6'd59;
  localparam logic [5:0] ROM_DIE_REV = 6'd60;
  localparam logic [5:0] ROM_UNIPOLAR = 6'd61;
  localparam logic [5:0] ROM_NUM_AMPS = 6'd62;
  localparam logic [5:0] ROM_CHIP_ID = 6'd63;

  localparam logic [7:0] ROM_MISO_AB_VAL = 8'h53;
  localparam logic [7:0] ROM_DIE_REV_VAL = 8'h01;
  localparam logic [7:0] ROM_UNIPOLAR_VAL = 8'h01;

  typedef enum logic [2:0] {
    OP_CONVERT,
    OP_CALIBRATE,
    OP_CLEAR,
    OP_WRITE,
    OP_READ,
    OP_OTHER
  } op_e;

  function automatic op_e classify(input logic [15:0] cmd);
    op_e op;
    op = OP_OTHER;
    unique case (1'b1)
      (cmd[15:14] == CMD_CONVERT) && (cmd[7:1] == 7'd0):
        op = OP_CONVERT;
      cmd == CMD_CALIBRATE: op = OP_CALIBRATE;
      cmd == CMD_CLEAR: op = OP_CLEAR;
      cmd[15:14] == CMD_WRITE: op = OP_WRITE;
      cmd[15:14] == CMD_READ: op = OP_READ;
      default: op = OP_OTHER;
    endcase
    return op;
  endfunction

  function automatic logic [7:0] rom_read(
    input logic [5:0] r,
    input logic [7:0] num_amps,
    input logic [7:0] chip_id
  );
    logic [7:0] v;
    v = 8'h00;
    unique case (r)
      ROM_NAME_0: v = 8'h49;
      ROM_NAME_1: v = 8'h4E;
      ROM_NAME_2: v = 8'h54;
      ROM_NAME_3: v = 8'h41;
      ROM_NAME_4: v = 8'h4E;
      ROM_MISO_AB: v = ROM_MISO_AB_VAL;
      ROM_DIE_REV: v = ROM_DIE_REV_VAL;
      ROM_UNIPOLAR: v = ROM_UNIPOLAR_VAL;
      ROM_NUM_AMPS: v = num_amps;
      ROM_CHIP_ID: v = chip_id;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rhd_emu_edge_sync.sv
// Two-flop synchronizer for one asynchronous pin with registered edge pulses.
// RST_VAL sets the idle level so reset release does not fake an edge.
module rhd_emu_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [2:0] sr;

  // two synchronizer stages followed by the previous-value register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr <= {3{RST_VAL}};
    end else begin
      sr <= {sr[1:0], din};
    end
  end

  // one-clk edge pulses, registered
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= sr[1] & ~sr[2];
      fall <= ~sr[1] & sr[2];
    end
  end

endmodule

// File: rtl/rhd_chip_emulator.sv
// RHD2000 chip-side responder: oversampled SPI slave, command decoder,
// register file and two-frame result pipeline on a single MISO line.
module rhd_chip_emulator
  import rhd_emu_pkg::*;
#(
  parameter logic [15:0] SEED = 16'd0,
  parameter logic [7:0] NUM_AMPS = 8'd64,
  parameter logic [7:0] CHIP_ID = 8'd2
) (
  input  logic clk,
  input  logic rstn,
  input  logic SCLK,
  input  logic CS,
  input  logic MOSI,
  output logic MISO,
  output logic reg_wr_valid,
  output logic [5:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic frame_err
);

  logic sclk_rise;
  logic sclk_fall;
  logic cs_rise;
  logic cs_fall;
  logic [1:0] mosi_ff;
  logic mosi_s;

  logic in_frame;
  logic [4:0] bit_cnt;
  logic [15:0] cmd_sr;
  logic [15:0] tx_sr;
  logic [15:0] res_q [2];
  logic [7:0] regs [RHD_NUM_WR_REGS];

  op_e op;
  logic [5:0] r;
  logic [7:0] d;
  logic in_wr_range;
  logic [7:0] reg_rd;
  logic [15:0] result;
  logic wr_hit;
  logic accept;

  rhd_emu_edge_sync #(
    .RST_VAL(1'b0)
  ) u_sclk_sync (
    .clk(clk),
    .rstn(rstn),
    .din(SCLK),
    .rise(sclk_rise),
    .fall(sclk_fall)
  );

  rhd_emu_edge_sync #(
    .RST_VAL(1'b1)
  ) u_cs_sync (
    .clk(clk),
    .rstn(rstn),
    .din(CS),
    .rise(cs_rise),
    .fall(cs_fall)
  );

  // MOSI only needs a plain synchronizer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mosi_ff <= 2'b00;
    end else begin
      mosi_ff <= {mosi_ff[0], MOSI};
    end
  end

  assign mosi_s = mosi_ff[1];

  assign op = classify(cmd_sr);
  assign r = cmd_sr[13:8];
  assign d = cmd_sr[7:0];
  assign in_wr_range = {2'b00, r} < 8'(RHD_NUM_WR_REGS);
  assign accept = cs_rise & (bit_cnt == 5'd16);

  // register-file read port
  always_comb begin
    reg_rd = 8'h00;
    for (int i = 0; i < RHD_NUM_WR_REGS; i++) begin
      if (r == 6'(i)) begin
        reg_rd = regs[i];
      end
    end
  end

  // command decode into a 16-bit result word
  always_comb begin
    result = 16'h0000;
    wr_hit = 1'b0;
    unique case (1'b1)
      op == OP_CONVERT: begin
        if ({2'b00, r} < NUM_AMPS) begin
          result = SEED + {10'd0, r};
        end
      end
      op == OP_WRITE: begin
        result = {8'hFF, d};
        wr_hit = in_wr_range;
      end
      op == OP_READ: begin
        if (in_wr_range) begin
          result = {8'h00, reg_rd};
        end else begin
          result = {8'h00, rom_read(r, NUM_AMPS, CHIP_ID)};
        end
      end
      default: result = 16'h0000;
    endcase
  end

  // frame tracking, command shift-in and result shift-out
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_frame <= 1'b0;
      bit_cnt <= 5'd0;
      cmd_sr <= 16'h0000;
      tx_sr <= 16'h0000;
      MISO <= 1'b0;
    end else if (cs_fall) begin
      in_frame <= 1'b1;
      bit_cnt <= 5'd0;
      tx_sr <= res_q[1];
      MISO <= res_q[1][15];
    end else if (cs_rise || !in_frame) begin
      in_frame <= 1'b0;
      MISO <= 1'b0;
    end else begin
      if (sclk_rise) begin
        cmd_sr <= {cmd_sr[14:0], mosi_s};
        if (bit_cnt != 5'd31) begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
      if (sclk_fall) begin
        tx_sr <= {tx_sr[14:0], 1'b0};
        MISO <= tx_sr[14];
      end
    end
  end

  // frame close: advance pipeline, report writes or framing errors
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_q[0] <= 16'h0000;
      res_q[1] <= 16'h0000;
      reg_wr_valid <= 1'b0;
      reg_wr_addr <= 6'd0;
      reg_wr_data <= 8'h00;
      frame_err <= 1'b0;
    end else begin
      reg_wr_valid <= 1'b0;
      frame_err <= 1'b0;
      if (accept) begin
        res_q[1] <= res_q[0];
        res_q[0] <= result;
        if (wr_hit) begin
          reg_wr_valid <= 1'b1;
          reg_wr_addr <= r;
          reg_wr_data <= d;
        end
      end else if (cs_rise) begin
        frame_err <= 1'b1;
      end
    end
  end

  // writable register file
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RHD_NUM_WR_REGS; i++) begin
        regs[i] <= 8'h00;
      end
    end else if (accept && wr_hit) begin
      for (int i = 0; i < RHD_NUM_WR_REGS; i++) begin
        if (r == 6'(i)) begin
          regs[i] <= d;
        end
      end
    end
  end

endmodule

// File: tb/tb_rhd_chip_emulator.sv
// Bench for rhd_chip_emulator: directed frames with literal expectations
// plus a behavioural protocol model with a two-frame result delay.
module tb_rhd_chip_emulator;

  localparam int SEED_V = 144;
  localparam int NUM_V = 64;
  localparam int CHIP_V = 2;

  logic clk = 1'b0;
  logic rstn;
  logic SCLK;
  logic CS;
  logic MOSI;
  logic MISO;
  logic reg_wr_valid;
  logic [5:0] reg_wr_addr;
  logic [7:0] reg_wr_data;
  logic frame_err;

  rhd_chip_emulator #(
    .SEED(16'(SEED_V)),
    .NUM_AMPS(8'(NUM_V)),
    .CHIP_ID(8'(CHIP_V))
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .SCLK(SCLK),
    .CS(CS),
    .MOSI(MOSI),
    .MISO(MISO),
    .reg_wr_valid(reg_wr_valid),
    .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  logic [5:0] wr_a = '0;
  logic [7:0] wr_d = '0;

  logic [7:0] mregs [18];
  logic [15:0] p0;
  logic [15:0] p1;
  logic [5:0] exp_a;
  logic [7:0] exp_d;

  always @(negedge clk) begin
    if (reg_wr_valid) begin
      wr_cnt++;
      wr_a = reg_wr_addr;
      wr_d = reg_wr_data;
    end
    if (frame_err) err_cnt++;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [15:0] conv(input int c);
    return {2'b00, 6'(c), 8'h00};
  endfunction

  function automatic logic [15:0] wr(input int a, input int v);
    return {2'b10, 6'(a), 8'(v)};
  endfunction

  function automatic logic [15:0] rd(input int a);
    return {2'b11, 6'(a), 8'h00};
  endfunction

  task automatic model_reset();
    foreach (mregs[i]) mregs[i] = 8'h00;
    p0 = 16'h0000;
    p1 = 16'h0000;
  endtask

  task automatic model_exec(input logic [15:0] c, output logic [15:0] res,
                            output bit w);
    int op;
    int ra;
    int dv;
    string rom;
    rom = "INTAN";
    op = int'(c) / 16384;
    ra = (int'(c) / 256) % 64;
    dv = int'(c) % 256;
    res = 16'h0000;
    w = 1'b0;
    if (op == 0 && dv < 2) begin
      if (ra < NUM_V) res = 16'((SEED_V + ra) % 65536);
    end else if (op == 2) begin
      res = 16'(65280 + dv);
      if (ra <= 17) begin
        mregs[ra] = 8'(dv);
        w = 1'b1;
        exp_a = 6'(ra);
        exp_d = 8'(dv);
      end
    end else if (op == 3) begin
      if (ra <= 17) res = {8'h00, mregs[ra]};
      else if (ra >= 40 && ra <= 44) res = {8'h00, rom[ra-40]};
      else if (ra == 59) res = 16'h0053;
      else if (ra == 60 || ra == 61) res = 16'h0001;
      else if (ra == 62) res = 16'(NUM_V);
      else if (ra == 63) res = 16'(CHIP_V);
    end
  endtask

  task automatic run_frame(input logic [15:0] cmd, input int nbits,
                           input int h, output logic [15:0] word);
    word = 16'h0000;
    @(negedge clk);
    CS = 1'b0;
    MOSI = cmd[15];
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b1;
      repeat (h) @(negedge clk);
      word = {word[14:0], MISO};
      SCLK = 1'b0;
      MOSI = (i < 15) ? cmd[14-i] : 1'b0;
      repeat (h) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    CS = 1'b1;
    MOSI = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_frame(input logic [15:0] cmd, input int nbits,
                          input int h, output logic [15:0] word);
    int w0;
    int e0;
    logic [15:0] res;
    bit w;
    w0 = wr_cnt;
    e0 = err_cnt;
    run_frame(cmd, nbits, h, word);
    if (nbits == 16) begin
      chk("miso_word", word, p1);
      model_exec(cmd, res, w);
      p1 = p0;
      p0 = res;
      chk("wr_pulses", 16'(wr_cnt - w0), w ? 16'd1 : 16'd0);
      if (w) begin
        chk("wr_addr", {10'd0, wr_a}, {10'd0, exp_a});
        chk("wr_data", {8'd0, wr_d}, {8'd0, exp_d});
      end
      chk("frame_err_none", 16'(err_cnt - e0), 16'd0);
    end else begin
      chk("miso_partial", word, p1 >> (16 - nbits));
      chk("frame_err_pulse", 16'(err_cnt - e0), 16'd1);
      chk("wr_none", 16'(wr_cnt - w0), 16'd0);
    end
    chk("miso_idle", {15'd0, MISO}, 16'd0);
  endtask

  task automatic reset_midframe();
    @(negedge clk);
    CS = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      SCLK = 1'b1;
      repeat (2) @(negedge clk);
      SCLK = 1'b0;
      repeat (2) @(negedge clk);
    end
    SCLK = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_miso", {15'd0, MISO}, 16'd0);
    chk("rst_wr_valid", {15'd0, reg_wr_valid}, 16'd0);
    CS = 1'b1;
    SCLK = 1'b0;
    MOSI = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    model_reset();
  endtask

  logic [15:0] w [9];
  logic [15:0] tmp;
  logic [15:0] rc;
  logic [15:0] intan [5];
  int wc0;

  initial begin
    intan[0] = 16'h0049;
    intan[1] = 16'h004E;
    intan[2] = 16'h0054;
    intan[3] = 16'h0041;
    intan[4] = 16'h004E;
    rstn = 1'b0;
    CS = 1'b1;
    SCLK = 1'b0;
    MOSI = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    chk("reset_miso", {15'd0, MISO}, 16'd0);
    chk("reset_wr_valid", {15'd0, reg_wr_valid}, 16'd0);
    chk("reset_frame_err", {15'd0, frame_err}, 16'd0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 3; i++) do_frame(conv(5), 16, 2, w[i]);
    chk("conv_w0", w[0], 16'h0000);
    chk("conv_w1", w[1], 16'h0000);
    chk("conv_w2", w[2], 16'h0095);

    wc0 = wr_cnt;
    do_frame(wr(3, 8'hA5), 16, 2, w[0]);
    do_frame(rd(3), 16, 2, w[1]);
    do_frame(rd(63), 16, 2, w[2]);
    do_frame(conv(0), 16, 2, w[3]);
    do_frame(conv(0), 16, 2, w[4]);
    chk("wr_w3", w[2], 16'hFFA5);
    chk("rd3_w4", w[3], 16'h00A5);
    chk("rd63_w5", w[4], 16'h0002);
    chk("wr_once", 16'(wr_cnt - wc0), 16'd1);
    chk("wr_addr_lit", {10'd0, wr_a}, 16'd3);
    chk("wr_data_lit", {8'd0, wr_d}, 16'h00A5);

    wc0 = wr_cnt;
    for (int i = 0; i < 5; i++) do_frame(rd(40 + i), 16, 2, w[i]);
    do_frame(wr(40, 0), 16, 2, w[5]);
    do_frame(rd(40), 16, 2, w[6]);
    do_frame(conv(0), 16, 2, w[7]);
    do_frame(conv(0), 16, 2, w[8]);
    for (int i = 0; i < 5; i++) chk("intan", w[i+2], intan[i]);
    chk("wr40_ret", w[7], 16'hFF00);
    chk("rd40_after", w[8], 16'h0049);
    chk("wr40_no_pulse", 16'(wr_cnt - wc0), 16'd0);

    wc0 = err_cnt;
    do_frame(conv(10), 16, 2, tmp);
    do_frame(conv(11), 16, 2, tmp);
    do_frame(conv(20), 15, 2, tmp);
    do_frame(conv(12), 16, 2, w[0]);
    do_frame(conv(13), 16, 2, w[1]);
    do_frame(conv(14), 16, 2, w[2]);
    chk("err_once", 16'(err_cnt - wc0), 16'd1);
    chk("after_err0", w[0], 16'h009A);
    chk("after_err1", w[1], 16'h009B);
    chk("after_err2", w[2], 16'h009C);

    do_frame(wr(3, 8'hA5), 16, 2, tmp);
    do_frame(conv(1), 16, 2, tmp);
    reset_midframe();
    do_frame(rd(3), 16, 2, w[0]);
    do_frame(conv(0), 16, 2, w[1]);
    do_frame(conv(0), 16, 2, w[2]);
    chk("post_rst_w0", w[0], 16'h0000);
    chk("post_rst_w1", w[1], 16'h0000);
    chk("post_rst_rd3", w[2], 16'h0000);

    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < 200; n++) begin
        case ($urandom_range(0, 5))
          0: rc = {2'b00, 6'($urandom_range(0, 63)), 7'd0,
                   1'($urandom_range(0, 1))};
          1: rc = 16'h5500;
          2: rc = 16'h6A00;
          3: rc = wr($urandom_range(0, 23), $urandom_range(0, 255));
          4: rc = {2'b11, 6'($urandom_range(0, 63)),
                   8'($urandom_range(0, 255))};
          default: rc = 16'($urandom);
        endcase
        do_frame(rc, 16, (s == 0) ? 2 : 5, tmp);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
